// File: rtl/dev_a_burst_master.sv
// Shared-bus master: buffers words in a FIFO, arbitrates with req/gnt and sends bursts to device B.
// Define DEVA_TIMEOUT_EN to build the acceptedB timeout (err_timeout); otherwise err_timeout is 0.
module dev_a_burst_master #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned BURST   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       clkA1,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       gntA1,
  input  logic                       acceptedB,
  output logic                       reqA1,
  output logic                       readyA1,
  output logic                       bus_oe,
  output logic [WIDTH-1:0]           sharedBus,
  output logic                       err_timeout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACC,
    S_ACK_LOW,
    S_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              ready_q, ready_d;
  logic              oe_q, oe_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  head;

`ifdef DEVA_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;
`endif

  assign head = mem_q[rd_ptr_q];

  // FSM next state, registered bus outputs and FIFO bookkeeping
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ready_d = ready_q;
    oe_d    = oe_q;
    data_d  = data_q;
    beat_d  = beat_q;
    pop     = 1'b0;
`ifdef DEVA_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          state_d = S_REQ;
          req_d   = 1'b1;
        end
      end
      S_REQ: begin
        if (gntA1) begin
          state_d = S_WAIT_ACC;
          data_d  = head;
          oe_d    = 1'b1;
          ready_d = 1'b1;
          beat_d  = BW'(1);
`ifdef DEVA_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      S_WAIT_ACC: begin
        // accept beats a simultaneous grant loss; an aborted word stays in the FIFO
        if (acceptedB) begin
          pop     = 1'b1;
          ready_d = 1'b0;
          state_d = S_ACK_LOW;
        end else if (!gntA1) begin
          ready_d = 1'b0;
          oe_d    = 1'b0;
          data_d  = '0;
          req_d   = 1'b0;
          state_d = S_RELEASE;
        end
`ifdef DEVA_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          ready_d = 1'b0;
          oe_d    = 1'b0;
          data_d  = '0;
          req_d   = 1'b0;
          state_d = S_RELEASE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      S_ACK_LOW: begin
        if (!acceptedB) begin
          if ((beat_q < BW'(BURST)) && !empty_q && gntA1) begin
            data_d  = head;
            ready_d = 1'b1;
            beat_d  = beat_q + BW'(1);
            state_d = S_WAIT_ACC;
`ifdef DEVA_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            oe_d    = 1'b0;
            data_d  = '0;
            req_d   = 1'b0;
            state_d = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (!gntA1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    push     = wr_en && !full_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    empty_d  = (count_d == '0);
    full_d   = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clkA1 or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      ready_q  <= 1'b0;
      oe_q     <= 1'b0;
      data_q   <= '0;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
`ifdef DEVA_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      ready_q  <= ready_d;
      oe_q     <= oe_d;
      data_q   <= data_d;
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
`ifdef DEVA_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  // storage needs no reset: the pointers define what is valid
  always_ff @(posedge clkA1) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign reqA1     = req_q;
  assign readyA1   = ready_q;
  assign bus_oe    = oe_q;
  assign sharedBus = data_q;
  assign count     = count_q;
  assign empty     = empty_q;
  assign full      = full_q;

`ifdef DEVA_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
  // TIMEOUT only sizes the accept timeout; nothing is built for it here
  if (TIMEOUT < 2) begin : g_timeout_unused
  end
`endif

endmodule
